// File: rtl/wide_add_sequencer.sv
// Multi-word adder that streams NWORDS 32-bit word pairs through one external
// 32-bit adder, least-significant word first, rippling the carry between words.
module wide_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*NWORDS-1:0]   op_a,
  input  logic [32*NWORDS-1:0]   op_b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NWORDS-1:0]   result,
  output logic                   cout,
  output logic [31:0]            adder_a,
  output logic [31:0]            adder_b,
  output logic                   adder_cin,
  input  logic [31:0]            adder_sum,
  input  logic                   adder_cout
);
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic [NWORDS-1:0][31:0] a_q, b_q, res_q;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = res_q;

  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state == S_RUN) begin
      adder_a   = a_q[idx];
      adder_b   = b_q[idx];
      adder_cin = carry;
    end
  end

  // Operands are latched only on accept, so input changes mid-operation are invisible.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      res_q <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          carry <= cin;
          idx   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          res_q[idx] <= adder_sum;
          carry      <= adder_cout;
          if (idx == LAST) begin
            cout  <= adder_cout;
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // Handshake edge returns to IDLE only; earliest next accept is one cycle later.
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// 32-bit carry-skip adder: 4-bit ripple blocks, carry bypasses a block whose bits all propagate.
module carry_skip_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] c;
  assign c[0] = cin;

  for (genvar g = 0; g < 8; g++) begin : g_blk
    logic [4:0] rc;
    logic [3:0] p;
    assign rc[0] = c[g];
    assign p     = a[4*g +: 4] ^ b[4*g +: 4];
    for (genvar i = 0; i < 4; i++) begin : g_bit
      assign sum[4*g+i] = p[i] ^ rc[i];
      assign rc[i+1]    = (a[4*g+i] & b[4*g+i]) | (p[i] & rc[i]);
    end
    assign c[g+1] = (&p) ? c[g] : rc[4];
  end

  assign cout = c[8];
endmodule
